// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulo counter family.
package counter_pkg;

  localparam int unsigned CNT_MODE_WRAP = 0;
  localparam int unsigned CNT_MODE_SAT  = 1;

  localparam logic CNT_DIR_DOWN = 1'b0;
  localparam logic CNT_DIR_UP   = 1'b1;

endpackage : counter_pkg

// File: rtl/count_prescaler.sv
// Enable prescaler: cycles 0..PRESCALE-1 on enabled clocks; tick marks the last phase.
module count_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("count_prescaler: PRESCALE must be >= 1");
  end

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With PRESCALE=1 LAST is 0 and the phase never leaves 0, so tick is constant high.
  assign tick = (cnt_q == LAST);

endmodule : count_prescaler

// File: rtl/updown_mod_counter.sv
// Up/down counter modulo MAX_VAL+1 with wrap/saturate boundary mode,
// enable prescaler, clamped load, terminal-count pulse and sticky boundary flag.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
  parameter int unsigned SATURATE = CNT_MODE_WRAP,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
  localparam bit               SAT_MODE = (SATURATE == CNT_MODE_SAT);

  if ((MAX_VAL < 1) || (64'(MAX_VAL) > ((64'(1) << WIDTH) - 64'(1)))) begin : g_bad_max
    $error("updown_mod_counter: MAX_VAL must lie in 1..2**WIDTH-1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("updown_mod_counter: PRESCALE must be >= 1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick_c;
  logic             step_c;

  count_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (clear | load),
    .en    (en),
    .tick  (tick_c)
  );

  assign step_c = en & tick_c;

  // Next state in priority order clear > load > step > hold; reset is applied in the register.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = (load_val > MAX_W) ? MAX_W : load_val;
    end else if (step_c) begin
      if (up_dn == CNT_DIR_UP) begin
        if (count_q >= MAX_W) begin
          count_d = SAT_MODE ? MAX_W : '0;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = SAT_MODE ? '0 : MAX_W;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule : updown_mod_counter
